apb_master: RTL

APB requester that turns single-beat commands from a local valid/ready command port into APB SETUP/ACCESS transfers. It drives one APB slave segment (PSELx/PENABLE/PADDR/PWRITE/PWDATA), waits on PREADY and returns read data and error status on a held response port. A programmable ACCESS-phase timeout guards against a slave that never asserts PREADY.

---
 rtl/apb_master_if.sv | 36 +++
 rtl/apb_master.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/apb_master_if.sv
// Bundles the local command/response port and the APB segment signals driven by apb_master.
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master.sv
// Single-beat APB requester: command port -> SETUP/ACCESS transfer -> held response,
// with an optional ACCESS-phase timeout for slaves that never raise PREADY.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          RESETn,
  apb_master_if.master  bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } state_t;

  state_t            state_r, state_next_s;
  logic [CNT_W-1:0]  cnt_r, cnt_next_s;
  logic              psel_r, psel_next_s;
  logic              penable_r, penable_next_s;
  logic              pwrite_r, pwrite_next_s;
  logic [ADDR_W-1:0] paddr_r, paddr_next_s;
  logic [DATA_W-1:0] pwdata_r, pwdata_next_s;
  logic              rsp_valid_r, rsp_valid_next_s;
  logic              rsp_err_r, rsp_err_next_s;
  logic              rsp_timeout_r, rsp_timeout_next_s;
  logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_next_s;
  logic              cmd_ready_s;

  // Ready only when idle and no response is waiting, so cmd_valid never feeds back into cmd_ready.
  assign cmd_ready_s = (state_r == ST_IDLE) & ~rsp_valid_r;

  // Next-state and next-output computation; every register holds unless a branch says otherwise.
  always_comb begin
    state_next_s       = state_r;
    cnt_next_s         = cnt_r;
    psel_next_s        = psel_r;
    penable_next_s     = penable_r;
    pwrite_next_s      = pwrite_r;
    paddr_next_s       = paddr_r;
    pwdata_next_s      = pwdata_r;
    rsp_valid_next_s   = rsp_valid_r;
    rsp_err_next_s     = rsp_err_r;
    rsp_timeout_next_s = rsp_timeout_r;
    rsp_rdata_next_s   = rsp_rdata_r;

    if (rsp_valid_r && bus.rsp_ready) begin
      rsp_valid_next_s   = 1'b0;
      rsp_err_next_s     = 1'b0;
      rsp_timeout_next_s = 1'b0;
    end else begin
      rsp_valid_next_s   = rsp_valid_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_s) begin
          state_next_s   = ST_SETUP;
          paddr_next_s   = bus.cmd_addr;
          pwrite_next_s  = bus.cmd_write;
          pwdata_next_s  = bus.cmd_wdata;
          psel_next_s    = 1'b1;
          penable_next_s = 1'b0;
        end else begin
          psel_next_s    = 1'b0;
          penable_next_s = 1'b0;
        end
      end
      ST_SETUP: begin
        state_next_s   = ST_ACCESS;
        penable_next_s = 1'b1;
        cnt_next_s     = {CNT_W{1'b0}};
      end
      ST_ACCESS: begin
        if (bus.PREADY) begin
          state_next_s       = ST_IDLE;
          psel_next_s        = 1'b0;
          penable_next_s     = 1'b0;
          rsp_valid_next_s   = 1'b1;
          rsp_err_next_s     = bus.PSLVERR;
          rsp_timeout_next_s = 1'b0;
          rsp_rdata_next_s   = pwrite_r ? {DATA_W{1'b0}} : bus.PRDATA;
        end else if (TO_EN && (cnt_r == CNT_LAST)) begin
          // The counter reaches TIMEOUT-1 on the last allowed ACCESS cycle.
          state_next_s       = ST_IDLE;
          psel_next_s        = 1'b0;
          penable_next_s     = 1'b0;
          rsp_valid_next_s   = 1'b1;
          rsp_err_next_s     = 1'b1;
          rsp_timeout_next_s = 1'b1;
          rsp_rdata_next_s   = {DATA_W{1'b0}};
        end else begin
          cnt_next_s         = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_next_s   = ST_IDLE;
        psel_next_s    = 1'b0;
        penable_next_s = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      psel_r        <= 1'b0;
      penable_r     <= 1'b0;
      pwrite_r      <= 1'b0;
      paddr_r       <= {ADDR_W{1'b0}};
      pwdata_r      <= {DATA_W{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
      rsp_rdata_r   <= {DATA_W{1'b0}};
    end else begin
      state_r       <= state_next_s;
      cnt_r         <= cnt_next_s;
      psel_r        <= psel_next_s;
      penable_r     <= penable_next_s;
      pwrite_r      <= pwrite_next_s;
      paddr_r       <= paddr_next_s;
      pwdata_r      <= pwdata_next_s;
      rsp_valid_r   <= rsp_valid_next_s;
      rsp_err_r     <= rsp_err_next_s;
      rsp_timeout_r <= rsp_timeout_next_s;
      rsp_rdata_r   <= rsp_rdata_next_s;
    end
  end

  assign bus.cmd_ready   = cmd_ready_s;
  assign bus.PSELx       = psel_r;
  assign bus.PENABLE     = penable_r;
  assign bus.PWRITE      = pwrite_r;
  assign bus.PADDR       = paddr_r;
  assign bus.PWDATA      = pwdata_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_err     = rsp_err_r;
  assign bus.rsp_timeout = rsp_timeout_r;
  assign bus.rsp_rdata   = rsp_rdata_r;

endmodule
